// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that receives 16-bit command frames and holds the waveform generator config.
// SPI pins are oversampled in the clk domain; a status word is returned on miso.
module spi_cmd_rx #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [3:0]  DEFAULT_SEL  = 4'd0,
  parameter logic [11:0] DEFAULT_STEP = 12'd1,
  parameter logic [7:0]  DEFAULT_AMP  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [3:0]  selector,
  output logic [11:0] phase_step,
  output logic [7:0]  amplitude,
  output logic        cfg_update,
  output logic        frame_err,
  output logic [7:0]  frame_count
);

  // IDLE: wait for armed cs_n low | SHIFT: clock bits in/out | DECODE: apply frame (1 clk)
  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t state, state_next;

  logic [1:0]             rst_pipe;
  logic                   rst_sync_n;
  logic [SYNC_STAGES-1:0] sclk_pipe, cs_pipe, mosi_pipe;
  logic                   sclk_s, cs_s, mosi_s, sclk_prev;
  logic                   sclk_rise, sclk_fall;
  logic                   armed;
  logic [4:0]             bit_cnt;
  logic [15:0]            rx, tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  // cs_n sync resets low so a frame already in progress at reset release never looks like a start
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sclk_pipe <= '0;
      cs_pipe   <= '0;
      mosi_pipe <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign cs_s      = cs_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && !cs_s) state_next = SHIFT;
      SHIFT:   if (cs_s)           state_next = DECODE;
      DECODE:                      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      armed       <= 1'b0;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      selector    <= DEFAULT_SEL;
      phase_step  <= DEFAULT_STEP;
      amplitude   <= DEFAULT_AMP;
      cfg_update  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE && state_next == SHIFT) armed <= 1'b0;
      else if (cs_s)                             armed <= 1'b1;

      case (state)
        IDLE: begin
          if (state_next == SHIFT) begin
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= {4'hA, selector, frame_count};
          end
        end
        SHIFT: begin
          // an sclk edge coincident with cs_n release is dropped
          if (!cs_s) begin
            if (sclk_rise) begin
              rx <= {rx[14:0], mosi_s};
              if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall) tx <= {tx[14:0], 1'b0};
          end
        end
        DECODE: begin
          if (bit_cnt == 5'd16) begin
            case (rx[15:12])
              4'h0: frame_count <= frame_count + 8'd1;
              4'h1: begin
                selector    <= rx[3:0];
                cfg_update  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
              4'h2: begin
                phase_step  <= rx[11:0];
                cfg_update  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
              4'h3: begin
                amplitude   <= rx[7:0];
                cfg_update  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
              4'hF: begin
                selector    <= DEFAULT_SEL;
                phase_step  <= DEFAULT_STEP;
                amplitude   <= DEFAULT_AMP;
                cfg_update  <= 1'b1;
                frame_count <= frame_count + 8'd1;
              end
              default: frame_err <= 1'b1;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign miso = (state == SHIFT) & tx[15];

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: bit-bangs SPI mode-0 frames at clk/8 and checks config,
// status readback, error pulses and frame counting against hand-computed values.
module tb_spi_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [3:0]  selector;
  logic [11:0] phase_step;
  logic [7:0]  amplitude;
  logic        cfg_update;
  logic        frame_err;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0;
  int err_cnt = 0;
  int cfg_base, err_base;
  logic [15:0] rd;

  spi_cmd_rx dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .selector(selector), .phase_step(phase_step), .amplitude(amplitude),
    .cfg_update(cfg_update), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_update) cfg_cnt <= cfg_cnt + 1;
    if (frame_err)  err_cnt <= err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one bit per 8 clk: mosi set with sclk low, miso sampled just before sclk rises
  task automatic shift_bits(input logic [31:0] data, input int nbits, output logic [15:0] r);
    r = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      tick(4);
      r = {r[14:0], miso};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input int nbits, output logic [15:0] r);
    cs_n = 1'b0;
    tick(8);
    shift_bits(data, nbits, r);
    tick(4);
    cs_n = 1'b1;
    tick(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  initial begin
    // reset, idle
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("rst_sel",   selector,    4'd0);
    check("rst_step",  phase_step,  12'd1);
    check("rst_amp",   amplitude,   8'd255);
    check("rst_count", frame_count, 8'd0);
    check("rst_miso",  miso,        1'b0);
    check("rst_cfg",   cfg_update,  1'b0);
    check("rst_err",   frame_err,   1'b0);

    // 0x1003 with latency check: update lands 4 clk after cs_n rises
    cs_n = 1'b0;
    tick(8);
    shift_bits(32'h1003, 16, rd);
    tick(4);
    cs_n = 1'b1;
    tick(3);
    check("lat_sel_before", selector, 4'd0);
    check("lat_cfg_before", cfg_update, 1'b0);
    tick(1);
    check("lat_sel_after", selector, 4'd3);
    check("lat_cfg_pulse", cfg_update, 1'b1);
    tick(1);
    check("cfg_one_clk", cfg_update, 1'b0);
    tick(8);
    check("f1_cfg_cnt", cfg_cnt, 1);
    check("f1_count", frame_count, 8'd1);
    check("f1_miso", rd, 16'hA000);
    check("f1_miso_idle", miso, 1'b0);

    // fresh start, then 0x2ABC and 0x3040
    do_reset();
    check("r2_sel", selector, 4'd0);
    check("r2_count", frame_count, 8'd0);
    cfg_base = cfg_cnt;
    send(32'h2ABC, 16, rd);
    check("f2_step", phase_step, 12'hABC);
    check("f2_miso", rd, 16'hA000);
    send(32'h3040, 16, rd);
    check("f3_amp", amplitude, 8'h40);
    check("f3_miso", rd, 16'hA001);
    check("f3_count", frame_count, 8'd2);
    check("f23_cfg", cfg_cnt - cfg_base, 2);

    // short and long frames
    err_base = err_cnt;
    cfg_base = cfg_cnt;
    send(32'h109, 12, rd);
    check("short_err", err_cnt - err_base, 1);
    send(32'h01009, 18, rd);
    check("long_err", err_cnt - err_base, 2);
    check("len_sel", selector, 4'd0);
    check("len_step", phase_step, 12'hABC);
    check("len_amp", amplitude, 8'h40);
    check("len_count", frame_count, 8'd2);
    check("len_cfg", cfg_cnt - cfg_base, 0);

    // empty frame: cs_n pulse with no sclk
    send(32'h0, 0, rd);
    check("empty_err", err_cnt - err_base, 3);
    check("empty_count", frame_count, 8'd2);

    // bad opcode, then defaults restore
    send(32'h7123, 16, rd);
    check("op7_err", err_cnt - err_base, 4);
    check("op7_count", frame_count, 8'd2);
    check("op7_step", phase_step, 12'hABC);
    send(32'hF000, 16, rd);
    check("opF_sel", selector, 4'd0);
    check("opF_step", phase_step, 12'd1);
    check("opF_amp", amplitude, 8'd255);
    check("opF_cfg", cfg_cnt - cfg_base, 1);
    check("opF_count", frame_count, 8'd3);
    check("opF_err", err_cnt - err_base, 4);

    // nondefault config including zero phase step
    send(32'h1009, 16, rd);
    check("cfg_sel9", selector, 4'd9);
    send(32'h2000, 16, rd);
    check("step_zero", phase_step, 12'd0);
    send(32'h3055, 16, rd);
    check("amp_55", amplitude, 8'h55);
    check("pre_rst_miso", rd, 16'hA905);
    check("pre_rst_count", frame_count, 8'd6);

    // reset mid-frame after 8 bits of 0x1005
    cs_n = 1'b0;
    tick(8);
    shift_bits(32'h10, 8, rd);
    rst_n = 1'b0;
    tick(2);
    check("mid_sel", selector, 4'd0);
    check("mid_step", phase_step, 12'd1);
    check("mid_amp", amplitude, 8'd255);
    check("mid_count", frame_count, 8'd0);
    check("mid_miso", miso, 1'b0);
    rst_n = 1'b1;
    tick(4);
    cfg_base = cfg_cnt;
    shift_bits(32'h05, 8, rd);
    tick(4);
    cs_n = 1'b1;
    tick(10);
    check("tail_sel", selector, 4'd0);
    check("tail_count", frame_count, 8'd0);
    check("tail_cfg", cfg_cnt - cfg_base, 0);
    send(32'h1005, 16, rd);
    check("after_sel", selector, 4'd5);
    check("after_count", frame_count, 8'd1);

    // 256 NOPs wrap frame_count
    do_reset();
    cfg_base = cfg_cnt;
    err_base = err_cnt;
    for (int i = 0; i < 256; i++) begin
      send(32'h0000, 16, rd);
      if (i == 254) check("nop_count_255", frame_count, 8'd255);
    end
    check("nop_last_miso", rd, 16'hA0FF);
    check("nop_wrap", frame_count, 8'd0);
    check("nop_cfg", cfg_cnt - cfg_base, 0);
    check("nop_err", err_cnt - err_base, 0);
    check("nop_sel", selector, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_rx.md
Name: spi_cmd_rx

Overview:
SPI slave command receiver in the FPGA client, directly upstream of the waveform generator top. Receives 16-bit command frames from the host MCU, decodes them, and holds the generator's configuration registers: waveform selector, phase step and amplitude. Runs entirely in the clk domain, with SPI pins oversampled through synchronisers. Returns a status word on miso during each frame.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the sclk/cs_n/mosi synchronisers (min 2)
DEFAULT_SEL, 0, selector value after reset
DEFAULT_STEP, 1, phase step value after reset
DEFAULT_AMP, 255, amplitude value after reset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0); max frequency clk/8
cs_n  input  1  SPI chip select, active low
mosi  input  1  SPI data in, MSB first
miso  output  1  SPI data out, MSB first; driven 0 when cs_n is high
selector  output  4  waveform select to generator
phase_step  output  12  phase accumulator increment to generator
amplitude  output  8  output scale to generator
cfg_update  output  1  one-clk pulse when any config register is written
frame_err  output  1  one-clk pulse on a malformed frame
frame_count  output  8  count of accepted frames, wraps 255 -> 0

Behaviour:
- Reset (async assert, sync deassert via internal 2-FF): selector=DEFAULT_SEL, phase_step=DEFAULT_STEP, amplitude=DEFAULT_AMP, miso=0, cfg_update=0, frame_err=0, frame_count=0, FSM=IDLE, bit counter=0, shift registers cleared.
- sclk, cs_n and mosi pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk. Sampling uses the synchronised mosi.
- FSM states: IDLE, SHIFT, DECODE.
- IDLE -> SHIFT on the synchronised cs_n falling edge. Clear the bit counter. Load the tx shift register with {4'hA, selector, frame_count}. Drive miso with tx bit 15.
- SHIFT: on each sclk rising edge, shift mosi into rx[0] (left shift) and increment the bit counter (5 bits, saturates at 17). On each sclk falling edge, shift tx left and drive miso with the new bit 15.
- SHIFT -> DECODE on the synchronised cs_n rising edge.
- DECODE (exactly 1 clk) -> IDLE. Frame is valid only if the bit counter is exactly 16.
  - Valid frame: decode rx[15:12] as the opcode.
    - 0x1: selector <= rx[3:0].
    - 0x2: phase_step <= rx[11:0]. A value of 0 is accepted (generator halts).
    - 0x3: amplitude <= rx[7:0].
    - 0x0: NOP, no register change.
    - 0xF: reset all three registers to their defaults.
    - Any other opcode: frame_err pulse, no register change, frame_count unchanged.
  - For opcodes 0x1, 0x2, 0x3 and 0xF: cfg_update pulses in the same cycle the register changes. For 0x0, 0x1, 0x2, 0x3 and 0xF: frame_count increments by 1.
  - Bit count other than 16 (short or long frame): frame_err pulses, no register change, frame_count unchanged.
- Latency: registers update on the clk edge that leaves DECODE. That edge is SYNC_STAGES+2 clk cycles after cs_n rises at the pin.
- A cs_n rising edge with no sclk edges (counter 0) is an error frame.
- Simultaneous sclk edge and cs_n rising edge in the same synchronised cycle: the sclk edge is ignored.
- sclk edges while in IDLE are ignored.
- A cs_n falling edge arriving during DECODE is handled in IDLE on the next cycle. The host must keep cs_n high for at least 4 clk.
- Reset asserted mid-frame aborts the frame and restores all defaults. Bits still arriving after rst_n deasserts are ignored until the next cs_n falling edge.
- Status readback reflects values latched at frame start, not values changed by the current frame.

Test Plan:
- Reset, then no activity -> selector=0, phase_step=1, amplitude=255, frame_count=0, miso=0.
- Frame 0x1003 at sclk=clk/8 -> selector=3, cfg_update pulses once, frame_count=1. miso shifts 0xA000 (status latched at frame start: selector=0, count=0).
- Frames 0x2ABC then 0x3040 -> phase_step=0xABC, amplitude=0x40, two cfg_update pulses, frame_count=2. The second frame's miso reads 0xA001.
- 12-bit frame (cs_n rises early), then an 18-bit frame -> two frame_err pulses, all registers and frame_count unchanged.
- Opcode 0x7 frame, then 0xF000 after nondefault config -> frame_err on the first. The second restores 0/1/255, pulses cfg_update and increments the count.
- Assert rst_n low mid-frame after 8 bits of 0x1005 -> defaults restored. Completing the frame after deassert yields no update, and the next full 0x1005 frame sets selector=5.
- 256 NOP frames -> frame_count wraps to 0, no cfg_update.
